// File: rtl/picomips_mc_core.sv
// picomips_mc_core: parametrised multi-cycle picoMIPS core with a two-state
// fetch/execute sequencer, a HALT state, a valid/ready input port and a
// registered output strobe. Program memory is an external asynchronous ROM.
// Optional Q1.(n-1) fractional multiplier (opcode 4): define PICOMIPS_MUL_EN.
module picomips_mc_core #(
    parameter int n     = 8,
    parameter int Psize = 6,
    parameter int NREG  = 16,
    parameter int Isize = n + 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [Psize-1:0] prog_addr,
    input  logic [Isize-1:0] prog_data,
    input  logic [n-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [n-1:0]     out_data,
    output logic             out_valid,
    output logic             halted,
    output logic [1:0]       flags
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_ADDI = 6'd2;
    localparam logic [5:0] OP_SUB  = 6'd3;
`ifdef PICOMIPS_MUL_EN
    localparam logic [5:0] OP_MUL  = 6'd4;
`endif
    localparam logic [5:0] OP_IN   = 6'd6;
    localparam logic [5:0] OP_OUT  = 6'd7;
    localparam logic [5:0] OP_BEQ  = 6'd8;
    localparam logic [5:0] OP_J    = 6'd9;
    localparam logic [5:0] OP_HALT = 6'd63;

    state_t             state_q, state_d;
    logic [Psize-1:0]   pc_q, pc_d;
    logic [Isize-1:0]   ir_q, ir_d;
    logic [n-1:0]       out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [1:0]         flags_q, flags_d;
    // R0 has no storage; it is synthesised as a constant zero on read.
    logic [n-1:0]       regs_q [1:NREG-1];

    logic [5:0]         op;
    logic [4:0]         rd, rs;
    logic [n-1:0]       imm;
    logic [n-1:0]       rd_val, rs_val;
    logic [Psize-1:0]   branch_tgt;
    logic               wr_en;
    logic [n-1:0]       wr_data;

    assign op         = ir_q[Isize-1 -: 6];
    assign rd         = ir_q[Isize-7 -: 5];
    assign rs         = ir_q[Isize-12 -: 5];
    assign imm        = ir_q[n-1:0];
    assign branch_tgt = Psize'(imm);

    // Register file read: R0 and indices beyond NREG read as zero
    always_comb begin
        rd_val = '0;
        rs_val = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (32'(rd) == i) rd_val = regs_q[i];
            if (32'(rs) == i) rs_val = regs_q[i];
        end
    end

`ifdef PICOMIPS_MUL_EN
    localparam int PW = 2 * n;
    logic signed [PW-1:0] mul_p;
    logic [n-1:0]         mul_res;

    // Signed fractional product, keeping bits [2n-2:n-1]
    always_comb begin
        mul_p   = PW'($signed(rd_val)) * PW'($signed(rs_val));
        mul_res = n'(mul_p >>> (n - 1));
    end
`endif

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            flags_q     <= '0;
            for (int unsigned i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
            if (wr_en) begin
                for (int unsigned i = 1; i < NREG; i++) begin
                    if (32'(rd) == i) regs_q[i] <= wr_data;
                end
            end
        end
    end

    // Next-state, PC and execute logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        flags_d     = flags_q;
        wr_en       = 1'b0;
        wr_data     = '0;
        case (state_q)
            FETCH: begin
                ir_d    = prog_data;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_q + 1'b1;
                case (op)
                    OP_ADD: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val + rs_val;
                        flags_d = {wr_data[n-1], wr_data == '0};
                    end
                    OP_ADDI: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val + imm;
                        flags_d = {wr_data[n-1], wr_data == '0};
                    end
                    OP_SUB: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val - rs_val;
                        flags_d = {wr_data[n-1], wr_data == '0};
                    end
`ifdef PICOMIPS_MUL_EN
                    OP_MUL: begin
                        wr_en   = 1'b1;
                        wr_data = mul_res;
                        flags_d = {wr_data[n-1], wr_data == '0};
                    end
`endif
                    OP_IN: begin
                        if (in_valid) begin
                            wr_en   = 1'b1;
                            wr_data = in_data;
                        end else begin
                            state_d = EXEC;
                            pc_d    = pc_q;
                        end
                    end
                    OP_OUT: begin
                        out_data_d  = rd_val;
                        out_valid_d = 1'b1;
                    end
                    OP_BEQ: begin
                        if (rd_val == rs_val) pc_d = branch_tgt;
                    end
                    OP_J: begin
                        pc_d = branch_tgt;
                    end
                    OP_HALT: begin
                        state_d = HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            HALT: ;
            default: state_d = FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        prog_addr = pc_q;
        out_data  = out_data_q;
        out_valid = out_valid_q;
        flags     = flags_q;
        halted    = (state_q == HALT);
        in_ready  = (state_q == EXEC) && (op == OP_IN);
    end

endmodule

// File: doc/picomips_mc_core.md
Name: picomips_mc_core

Overview:
- Parametrised, multi-cycle successor to the single-cycle picoMIPS CPU core.
- Generalises data width, register count and program size.
- Adds a two-state fetch/execute FSM, a valid/ready input port, a registered output strobe, a HALT state and an optional fractional multiplier for the matrix kernels.
- Program memory stays outside the core: an asynchronous ROM on prog_addr/prog_data.

Parameters:
- n, 8: data width, legal range 4..16.
- Psize, 6: program counter width; the program holds up to 2^Psize instructions.
- NREG, 16: number of general registers, legal range 2..32. R0 always reads 0.
- Isize, n+16: instruction width. Derived; do not override.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- prog_addr  out  Psize  program address, equal to PC
- prog_data  in  Isize  instruction at prog_addr, combinational, valid in the same cycle
- in_data  in  n  input operand
- in_valid  in  1  in_data is valid
- in_ready  out  1  core is accepting in_data
- out_data  out  n  last value written by OUT
- out_valid  out  1  one-cycle strobe when out_data updates
- halted  out  1  core is in HALT
- flags  out  2  {N,Z} from the last ALU operation

Behaviour:
- Instruction fields:
  - op = I[Isize-1:Isize-6]
  - rd = I[Isize-7:Isize-11]
  - rs = I[Isize-12:Isize-16]
  - imm = I[n-1:0]
  - Register indices >= NREG read as 0 and their writes are ignored.
- Reset (clk edge with reset=1) forces: PC=0, state=FETCH, all registers=0, IR=0, out_data=0, out_valid=0, flags=0, halted=0. in_ready is combinational and reads 0 in FETCH. Reset overrides every state, including mid-stall and HALT.
- FSM, states FETCH, EXEC, HALT:
  - FETCH: IR <= prog_data; go to EXEC (always 1 cycle).
  - EXEC: execute IR. On completion, PC <= branch target or PC+1, then go to FETCH. Unstalled CPI = 2.
  - HALT: PC, registers and outputs are frozen; halted=1. Leave only by reset.
- Opcodes (decimal; every unlisted opcode is a NOP that advances PC):
  - 0 NOP.
  - 1 ADD: rd=rd+rs.
  - 2 ADDI: rd=rd+imm.
  - 3 SUB: rd=rd-rs.
  - 4 MUL: see Optional Feature.
  - 6 IN: in_ready=1 while in EXEC with op=IN. Stall in EXEC until in_valid=1; on that cycle rd<=in_data and PC advances. If in_valid is already 1 on the first EXEC cycle, there is no stall.
  - 7 OUT: out_data<=rd value; out_valid=1 for exactly the following cycle (registered pulse).
  - 8 BEQ: if rd==rs, PC<=imm[Psize-1:0], else PC+1.
  - 9 J: PC<=imm[Psize-1:0].
  - 63 HALT: go to HALT; PC does not advance.
- Arithmetic is two's complement, modulo 2^n; overflow wraps silently.
- flags update only on ADD, ADDI, SUB and MUL: Z=(result==0), N=result[n-1]. All other opcodes preserve flags.
- Writes to R0 are discarded, and R0 still reads 0 afterwards.
- PC wraps from 2^Psize-1 to 0 with no error.
- out_valid is low in every cycle except the one after an OUT.

Optional Feature:
- Macro: PICOMIPS_MUL_EN.
- Defined: MUL (op 4) computes the signed product P=rd*rs (2n bits), then rd=P[2n-2:n-1] (Q1.(n-1) fractional result) and updates flags. Single EXEC cycle.
- Undefined: op 4 behaves as NOP (PC+1, flags unchanged, rd unchanged), and no multiplier is synthesised.

Test Plan:
- Reset/basic ALU: reset 2 cycles; program ADDI R1,5; ADDI R2,3; ADD R1,R2; OUT R1; HALT -> out_data=8 with one out_valid pulse on the cycle after OUT's EXEC; halted=1; flags=00; prog_addr stays on the HALT address.
- IN stall: IN R3 with in_valid held 0 for 5 cycles, then in_data=0x2A with in_valid=1 -> in_ready high for all 6 EXEC cycles; R3=0x2A; PC advances only on the transfer cycle; OUT R3 gives 0x2A.
- Branch/wrap: with Psize=6, BEQ R0,R0,imm=63 and J 0 at address 63 -> PC sequence reaches 63, then 0. With Psize=6, SUB R1,R1 then BEQ R1,R0 -> branch taken; flags Z=1.
- Overflow/R0: n=8; ADDI R1,0x7F; ADDI R1,1 -> R1=0x80, N=1, Z=0. ADDI R0,9; OUT R0 -> out_data=0.
- MUL: with PICOMIPS_MUL_EN, R1=0x40 (0.5), R2=0xC0 (-0.5), MUL R1,R2 -> R1=0xE0, N=1. Without the macro -> R1 stays 0x40.
- Reset mid-stall: assert reset while stalled on IN -> next cycle PC=0, in_ready=0, all registers 0, halted=0.
